apb_master_bridge: RTL and testbench

//   Request-to-APB bridge sitting directly upstream of the APB slave/UART register block.

---
 rtl/apb_master_bridge.sv | 147 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready request to APB SETUP/ACCESS sequencer.
// Optional build macro APB_TIMEOUT_EN aborts a stalled ACCESS phase and flags rsp_err.
module apb_master_bridge #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                psel_s, penable_s, pwrite_s;
  logic [ADDR_W-1:0]   paddr_s;
  logic [DATA_W-1:0]   pwdata_s;
  logic                rsp_valid_s, rsp_err_s;
  logic [DATA_W-1:0]   rsp_rdata_s;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    wait_cnt_r, wait_cnt_s;
`endif

  assign req_ready = (state_r == IDLE);

  // Next-state and next-value decode for every registered output
  always_comb begin
    state_s     = state_r;
    psel_s      = PSELx;
    penable_s   = PENABLE;
    pwrite_s    = PWRITE;
    paddr_s     = PADDR;
    pwdata_s    = PWDATA;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata;
    rsp_err_s   = rsp_err;
`ifdef APB_TIMEOUT_EN
    wait_cnt_s  = wait_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          psel_s    = 1'b1;
          penable_s = 1'b0;
          pwrite_s  = req_write;
          paddr_s   = req_addr;
          pwdata_s  = req_wdata;
          state_s   = SETUP;
        end else begin
          state_s   = IDLE;
        end
      end
      SETUP: begin
        penable_s = 1'b1;
        state_s   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_s = {CNT_W{1'b0}};
`endif
      end
      ACCESS: begin
        // Normal completion has priority over a timeout in the same cycle
        if (PREADY) begin
          psel_s      = 1'b0;
          penable_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_rdata_s = PWRITE ? {DATA_W{1'b0}} : PRDATA;
          state_s     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          psel_s      = 1'b0;
          penable_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_rdata_s = {DATA_W{1'b0}};
          state_s     = IDLE;
        end else begin
          wait_cnt_s  = wait_cnt_r + CNT_W'(1);
        end
`else
        else begin
          state_s = ACCESS;
        end
`endif
      end
      default: begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus and discards any transfer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r   <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= {ADDR_W{1'b0}};
      PWDATA    <= {DATA_W{1'b0}};
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_r <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r   <= state_s;
      PSELx     <= psel_s;
      PENABLE   <= penable_s;
      PWRITE    <= pwrite_s;
      PADDR     <= paddr_s;
      PWDATA    <= pwdata_s;
      rsp_valid <= rsp_valid_s;
      rsp_rdata <= rsp_rdata_s;
      rsp_err   <= rsp_err_s;
`ifdef APB_TIMEOUT_EN
      wait_cnt_r <= wait_cnt_s;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized scoreboard bench with an APB slave memory model.
// Expected responses come from a reference memory updated in request-acceptance order.
module tb_apb_master_bridge;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSELx, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
    logic          err;
    int            acc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] rmem[16];
  logic [DW-1:0] smem[16];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            max_wait = 0;
  int            fixed_wait = 0;
  bit            force_stall = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave: wait states and read data driven just after the edge, writes committed mid-cycle
  initial begin
    int s_cnt;
    int s_tgt;
    s_cnt = 0;
    s_tgt = 0;
    PREADY = 1'b0;
    PRDATA = '0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSELx && PENABLE) begin
        if (force_stall || s_cnt < s_tgt) begin
          PREADY = 1'b0;
          PRDATA = DW'($urandom);
          s_cnt++;
        end else begin
          PREADY = 1'b1;
          PRDATA = smem[PADDR];
        end
      end else begin
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = DW'($urandom);
        s_cnt  = 0;
        s_tgt  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
      end
      @(negedge PCLK);
      if (PRESETn && PSELx && PENABLE && PREADY && PWRITE) smem[PADDR] = PWDATA;
    end
  end

  // Monitor: scoreboard pops on rsp_valid, plus APB phase and handshake checks
  initial begin
    bit            p_setup, p_stall;
    logic [AW-1:0] p_a;
    logic          p_w;
    logic [DW-1:0] p_d;
    int            stalls;
    exp_t          e;
    p_setup = 1'b0;
    p_stall = 1'b0;
    stalls  = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        p_setup = 1'b0;
        p_stall = 1'b0;
        stalls  = 0;
      end else begin
        if (rsp_valid) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: rsp_valid=1 required 0 (no transfer outstanding, t=%0t)", $time);
          end else begin
            e = q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_latency", cyc - e.acc, e.err ? (2 + TO) : (3 + stalls));
          end
        end
        chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
        if (PENABLE) chk("penable_without_psel", 32'(PSELx), 32'd1);
        if (p_setup) chk("setup_one_cycle", 32'({PSELx, PENABLE}), 32'd3);
        if (p_stall && !(TO_EN && stalls >= TO)) begin
          chk("access_hold_ctrl", 32'({PSELx, PENABLE}), 32'd3);
          chk("access_hold_addr", 32'(PADDR), 32'(p_a));
          chk("access_hold_write", 32'(PWRITE), 32'(p_w));
          chk("access_hold_wdata", 32'(PWDATA), 32'(p_d));
        end
        if (PSELx && !PENABLE) begin
          stalls = 0;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_setup: PSELx=1 required 0 (no request accepted, t=%0t)", $time);
          end else begin
            chk("setup_paddr", 32'(PADDR), 32'(q[0].a));
            chk("setup_pwrite", 32'(PWRITE), 32'(q[0].w));
            chk("setup_pwdata", 32'(PWDATA), 32'(q[0].d));
          end
        end
        if (PSELx && PENABLE && !PREADY) stalls++;
        p_setup = PSELx && !PENABLE;
        p_stall = PSELx && PENABLE && !PREADY;
        p_a = PADDR;
        p_w = PWRITE;
        p_d = PWDATA;
      end
    end
  end

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit err, output int acc);
    exp_t e;
    int   budget;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    budget    = 0;
    acc       = -1;
    @(negedge PCLK);
    #1;
    while (!req_ready && budget < 200) begin
      @(negedge PCLK);
      #1;
      budget++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready=0 required 1 within 200 cycles");
    end else begin
      e.w   = w;
      e.a   = a;
      e.d   = d;
      e.err = err;
      e.acc = cyc;
      e.rd  = (w || err) ? '0 : rmem[a];
      if (w && !err) rmem[a] = d;
      q.push_back(e);
      acc = cyc;
    end
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (q.size() != 0 && b < 100) begin
      @(negedge PCLK);
      #1;
      b++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc1, acc2, b;
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) begin
      v = DW'($urandom);
      smem[i] = v;
      rmem[i] = v;
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    #12;
    chk("rst_psel", 32'(PSELx), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", 32'(PWDATA), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge PCLK);
    #1;

    // Zero-wait write then reads of the same register
    fixed_wait = 0;
    send(1'b1, 4'h3, 8'hA5, 1'b0, acc1);
    send(1'b0, 4'h3, 8'h00, 1'b0, acc1);
    send(1'b1, 4'h3, 8'h5A, 1'b0, acc1);
    send(1'b0, 4'h3, 8'hFF, 1'b0, acc1);
    wait_idle();

    // Three wait states on a read
    fixed_wait = 3;
    send(1'b0, 4'h3, 8'h11, 1'b0, acc1);
    wait_idle();

    // Back-to-back requests with req_valid held
    fixed_wait = 0;
    send(1'b1, 4'h1, 8'h3C, 1'b0, acc1);
    send(1'b1, 4'h2, 8'hC3, 1'b0, acc2);
    chk("b2b_spacing", acc2 - acc1, 32'd3);
    wait_idle();

`ifdef APB_TIMEOUT_EN
    // Stuck slave aborts, next transfer completes normally
    force_stall = 1'b1;
    send(1'b0, 4'h5, 8'h22, 1'b1, acc1);
    wait_idle();
    force_stall = 1'b0;
    send(1'b0, 4'h5, 8'h33, 1'b0, acc1);
    wait_idle();
`endif

    // Reset while the slave holds the bridge in ACCESS
    force_stall = 1'b1;
    send(1'b0, 4'h7, 8'h44, 1'b0, acc1);
    b = 0;
    while (!PENABLE && b < 10) begin
      @(negedge PCLK);
      b++;
    end
    chk("reached_access", 32'(PENABLE), 32'd1);
    @(posedge PCLK);
    #3;
    PRESETn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(PSELx), 32'd0);
    chk("async_rst_penable", 32'(PENABLE), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    q.delete();
    repeat (2) @(negedge PCLK);
    #1;
    PRESETn = 1'b1;
    force_stall = 1'b0;
    @(negedge PCLK);
    #1;
    chk("ready_after_midreset", 32'(req_ready), 32'd1);
    chk("no_rsp_after_midreset", 32'(rsp_valid), 32'd0);
    @(posedge PCLK);
    #1;

    // Randomized traffic with random wait states
    fixed_wait = -1;
    max_wait   = 3;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge PCLK);
        #1;
      end
      send(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'b0, acc1);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
